// File: rtl/bip_debug_pkg.sv
// Shared definitions for the BIP debug unit: FSM states, host command
// codes, frame header/length and the HLT opcode.
// Optional feature macro: BIP_DEBUG_CYCLE_COUNT_EN (appends the executed
// cycle count to the frame, 9 bytes instead of 7).
package bip_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_CAPTURE,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

  localparam logic [7:0] CMD_RUN   = 8'h01;
  localparam logic [7:0] CMD_STEP  = 8'h02;
  localparam logic [7:0] CMD_DUMP  = 8'h03;
  localparam logic [7:0] CMD_BREAK = 8'h04;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;
  localparam logic [4:0] HLT_OPCODE   = 5'b00000;

  localparam int unsigned FRAME_LEN_BASE = 7;
  localparam int unsigned FRAME_LEN_CNT  = 9;

`ifdef BIP_DEBUG_CYCLE_COUNT_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_CNT;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif

  // Byte index into the frame; wide enough for the longest frame.
  localparam int unsigned NB_IDX = 4;

endpackage

// File: rtl/bip_debug_frame_mux.sv
// Frame byte selector: returns the frame byte addressed by idx from the
// latched pc/instruction/acc (and cycle count when
// BIP_DEBUG_CYCLE_COUNT_EN is defined).
// Ports: pc, instruction, acc, [cycle_cnt], idx in; data_c out (combinational).
module bip_debug_frame_mux
  import bip_debug_pkg::*;
#(
  parameter int unsigned NB_DATA            = 16,
  parameter int unsigned LOG2_N_INSMEM_ADDR = 11,
  parameter int unsigned NB_UART_DATA       = 8
`ifdef BIP_DEBUG_CYCLE_COUNT_EN
  ,
  parameter int unsigned NB_CYCLE_CNT       = 16
`endif
) (
  input  logic [LOG2_N_INSMEM_ADDR-1:0] pc,
  input  logic [NB_DATA-1:0]            instruction,
  input  logic [NB_DATA-1:0]            acc,
`ifdef BIP_DEBUG_CYCLE_COUNT_EN
  input  logic [NB_CYCLE_CNT-1:0]       cycle_cnt,
`endif
  input  logic [NB_IDX-1:0]             idx,
  output logic [NB_UART_DATA-1:0]       data_c
);

  // Every field travels as a 16-bit big-endian pair (pc zero-extended).
  logic [15:0] pc_w;
  logic [15:0] instr_w;
  logic [15:0] acc_w;

  assign pc_w    = 16'(pc);
  assign instr_w = 16'(instruction);
  assign acc_w   = 16'(acc);

`ifdef BIP_DEBUG_CYCLE_COUNT_EN
  logic [15:0] cnt_w;
  assign cnt_w = 16'(cycle_cnt);
`endif

  always_comb begin
    data_c = '0;
    case (idx)
      NB_IDX'(0): data_c = NB_UART_DATA'(FRAME_HEADER);
      NB_IDX'(1): data_c = NB_UART_DATA'(pc_w[15:8]);
      NB_IDX'(2): data_c = NB_UART_DATA'(pc_w[7:0]);
      NB_IDX'(3): data_c = NB_UART_DATA'(instr_w[15:8]);
      NB_IDX'(4): data_c = NB_UART_DATA'(instr_w[7:0]);
      NB_IDX'(5): data_c = NB_UART_DATA'(acc_w[15:8]);
      NB_IDX'(6): data_c = NB_UART_DATA'(acc_w[7:0]);
`ifdef BIP_DEBUG_CYCLE_COUNT_EN
      NB_IDX'(7): data_c = NB_UART_DATA'(cnt_w[15:8]);
      NB_IDX'(8): data_c = NB_UART_DATA'(cnt_w[7:0]);
`endif
      default:    data_c = '0;
    endcase
  end

endmodule

// File: rtl/bip_debug_unit.sv
// Host debug controller for the BIP core. Decodes single-byte host
// commands (RUN/STEP/DUMP/BREAK), gates the core enable and, whenever the
// core stops, sends a pc/instruction/acc report frame through the UART TX
// handshake.
// Optional feature macro: BIP_DEBUG_CYCLE_COUNT_EN (saturating executed
// cycle counter appended to the frame).
// Ports:
//   i_clock, i_reset          clock, async active-high reset
//   i_rx_data, i_rx_done      received command byte + valid pulse
//   i_tx_done                 UART TX finished current byte
//   i_bip_pc/instruction/acc  core state to report
//   o_bip_valid               core clock-enable
//   o_tx_start, o_tx_data     TX start pulse and byte
//   o_busy                    unit not idle
module bip_debug_unit
  import bip_debug_pkg::*;
#(
  parameter int unsigned NB_DATA            = 16,
  parameter int unsigned NB_OPCODE          = 5,
  parameter int unsigned LOG2_N_INSMEM_ADDR = 11,
  parameter int unsigned NB_UART_DATA       = 8,
  parameter int unsigned NB_CYCLE_CNT       = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NB_UART_DATA-1:0]       i_rx_data,
  input  logic                          i_rx_done,
  input  logic                          i_tx_done,
  input  logic [LOG2_N_INSMEM_ADDR-1:0] i_bip_pc,
  input  logic [NB_DATA-1:0]            i_bip_instruction,
  input  logic [NB_DATA-1:0]            i_bip_acc,
  output logic                          o_bip_valid,
  output logic                          o_tx_start,
  output logic [NB_UART_DATA-1:0]       o_tx_data,
  output logic                          o_busy
);

  state_t                          state;
  logic [NB_IDX-1:0]               idx;
  logic [LOG2_N_INSMEM_ADDR-1:0]   pc_q;
  logic [NB_DATA-1:0]              instr_q;
  logic [NB_DATA-1:0]              acc_q;
  logic [NB_UART_DATA-1:0]         frame_byte_c;
  logic                            hlt_c;
  logic                            brk_c;

  assign hlt_c = (i_bip_instruction[NB_DATA-1 -: NB_OPCODE] == NB_OPCODE'(HLT_OPCODE));
  assign brk_c = i_rx_done && (i_rx_data == NB_UART_DATA'(CMD_BREAK));

`ifdef BIP_DEBUG_CYCLE_COUNT_EN
  logic [NB_CYCLE_CNT-1:0] cycle_cnt;
  logic [NB_CYCLE_CNT-1:0] cycle_cnt_q;

  // Saturating count of enabled core cycles; snapshot taken with the frame.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cycle_cnt   <= '0;
      cycle_cnt_q <= '0;
    end else begin
      if (o_bip_valid && (cycle_cnt != '1)) begin
        cycle_cnt <= cycle_cnt + NB_CYCLE_CNT'(1);
      end
      if (state == ST_CAPTURE) begin
        cycle_cnt_q <= cycle_cnt;
      end
    end
  end
`else
  // Counter width only matters when the counter is built.
  if (NB_CYCLE_CNT == 0) begin : g_no_cycle_cnt
  end
`endif

  bip_debug_frame_mux #(
    .NB_DATA            (NB_DATA),
    .LOG2_N_INSMEM_ADDR (LOG2_N_INSMEM_ADDR),
    .NB_UART_DATA       (NB_UART_DATA)
`ifdef BIP_DEBUG_CYCLE_COUNT_EN
    ,
    .NB_CYCLE_CNT       (NB_CYCLE_CNT)
`endif
  ) u_frame_mux (
    .pc          (pc_q),
    .instruction (instr_q),
    .acc         (acc_q),
`ifdef BIP_DEBUG_CYCLE_COUNT_EN
    .cycle_cnt   (cycle_cnt_q),
`endif
    .idx         (idx),
    .data_c      (frame_byte_c)
  );

  // Control FSM; outputs change together with the state they belong to.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      pc_q        <= '0;
      instr_q     <= '0;
      acc_q       <= '0;
      o_bip_valid <= 1'b0;
      o_tx_start  <= 1'b0;
      o_tx_data   <= '0;
      o_busy      <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_rx_done) begin
            if (i_rx_data == NB_UART_DATA'(CMD_RUN)) begin
              state       <= ST_RUN;
              o_bip_valid <= 1'b1;
              o_busy      <= 1'b1;
            end else if (i_rx_data == NB_UART_DATA'(CMD_STEP)) begin
              state       <= ST_STEP;
              o_bip_valid <= 1'b1;
              o_busy      <= 1'b1;
            end else if (i_rx_data == NB_UART_DATA'(CMD_DUMP)) begin
              state  <= ST_CAPTURE;
              o_busy <= 1'b1;
            end
          end
        end
        // HLT and BREAK together still produce a single stop.
        ST_RUN: begin
          if (hlt_c || brk_c) begin
            state       <= ST_CAPTURE;
            o_bip_valid <= 1'b0;
          end
        end
        ST_STEP: begin
          state       <= ST_CAPTURE;
          o_bip_valid <= 1'b0;
        end
        ST_CAPTURE: begin
          pc_q    <= i_bip_pc;
          instr_q <= i_bip_instruction;
          acc_q   <= i_bip_acc;
          idx     <= '0;
          state   <= ST_SEND;
        end
        ST_SEND: begin
          o_tx_start <= 1'b1;
          o_tx_data  <= frame_byte_c;
          state      <= ST_WAIT_TX;
        end
        // o_tx_data is held until the UART reports the byte done.
        ST_WAIT_TX: begin
          if (i_tx_done) begin
            if (idx == NB_IDX'(FRAME_LEN - 1)) begin
              idx    <= '0;
              state  <= ST_IDLE;
              o_busy <= 1'b0;
            end else begin
              idx   <= idx + NB_IDX'(1);
              state <= ST_SEND;
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          o_bip_valid <= 1'b0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bip_debug_unit.sv
// Directed self-checking bench for bip_debug_unit. Build with or without
// BIP_DEBUG_CYCLE_COUNT_EN; the expected frame length follows the macro.
module tb_bip_debug_unit;

`ifdef BIP_DEBUG_CYCLE_COUNT_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 7;
`endif

  logic        clock;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tx_done;
  logic [10:0] bip_pc;
  logic [15:0] bip_instruction;
  logic [15:0] bip_acc;
  logic        bip_valid;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cycles = 0;
  logic [7:0] exp_frame [9];

  bip_debug_unit dut (
    .i_clock           (clock),
    .i_reset           (reset),
    .i_rx_data         (rx_data),
    .i_rx_done         (rx_done),
    .i_tx_done         (tx_done),
    .i_bip_pc          (bip_pc),
    .i_bip_instruction (bip_instruction),
    .i_bip_acc         (bip_acc),
    .o_bip_valid       (bip_valid),
    .o_tx_start        (tx_start),
    .o_tx_data         (tx_data),
    .o_busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count cycles in which the core was enabled.
  always @(negedge clock) begin
    if (bip_valid === 1'b1) valid_cycles = valid_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    tx_done = 1'b0;
    repeat (2) @(negedge clock);
    valid_cycles = 0;
    reset = 1'b0;
  endtask

  // Pulse one command byte; returns at the negedge after the sampling edge.
  task automatic send_cmd(input logic [7:0] c);
    @(negedge clock);
    rx_data = c;
    rx_done = 1'b1;
    @(negedge clock);
    rx_done = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int t = 0;
    while (tx_start !== 1'b1 && t < 64) begin
      @(negedge clock);
      t++;
    end
    check({tag, "_start_seen"}, 32'(tx_start), 32'd1);
  endtask

  // Acts as the UART: 5-cycle done latency per byte; optionally injects a
  // command byte while byte inj_at is being transmitted.
  task automatic recv_frame(input string tag, input int nbytes, input int inj_at, input logic [7:0] inj_cmd);
    logic [7:0] held;
    for (int b = 0; b < nbytes; b++) begin
      wait_start($sformatf("%s_b%0d", tag, b));
      check($sformatf("%s_byte%0d", tag, b), 32'(tx_data), 32'(exp_frame[b]));
      held = tx_data;
      for (int k = 0; k < 4; k++) begin
        if (b == inj_at && k == 1) begin
          rx_data = inj_cmd;
          rx_done = 1'b1;
        end else begin
          rx_done = 1'b0;
        end
        @(negedge clock);
        check($sformatf("%s_hold%0d", tag, b), {23'd0, tx_start, tx_data}, {24'd0, held});
      end
      rx_done = 1'b0;
      tx_done = 1'b1;
      @(negedge clock);
      tx_done = 1'b0;
    end
    if (nbytes == FLEN) begin
      @(negedge clock);
      check({tag, "_idle_after"}, {30'd0, busy, tx_start}, 32'd0);
      repeat (10) @(negedge clock);
      check({tag, "_no_extra"}, {30'd0, busy, tx_start}, 32'd0);
    end
  endtask

  initial begin
    bip_pc = '0;
    bip_instruction = 16'h1000;
    bip_acc = '0;

    // Reset state and quiet idle.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      check("reset_outputs", {21'd0, bip_valid, tx_start, tx_data, busy}, 32'd0);
      @(negedge clock);
    end
    tx_done = 1'b1;
    @(negedge clock);
    tx_done = 1'b0;
    @(negedge clock);
    check("stray_tx_done", {30'd0, busy, tx_start}, 32'd0);

    // DUMP: report without executing.
    bip_pc = 11'h123; bip_instruction = 16'h0805; bip_acc = 16'hBEEF;
    exp_frame = '{8'hA5, 8'h01, 8'h23, 8'h08, 8'h05, 8'hBE, 8'hEF, 8'h00, 8'h00};
    valid_cycles = 0;
    send_cmd(8'h03);
    check("dump_busy", 32'(busy), 32'd1);
    recv_frame("dump", FLEN, -1, 8'h00);
    check("dump_no_valid", 32'(valid_cycles), 32'd0);

    // STEP: exactly one enabled cycle.
    do_reset();
    bip_pc = 11'h010; bip_instruction = 16'h1234; bip_acc = 16'h0042;
    exp_frame = '{8'hA5, 8'h00, 8'h10, 8'h12, 8'h34, 8'h00, 8'h42, 8'h00, 8'h01};
    send_cmd(8'h02);
    check("step_valid_on", 32'(bip_valid), 32'd1);
    @(negedge clock);
    check("step_valid_off", 32'(bip_valid), 32'd0);
    recv_frame("step", FLEN, -1, 8'h00);
    check("step_valid_cycles", 32'(valid_cycles), 32'd1);

    // RUN until HLT: 20 non-HLT cycles then HLT -> 21 enabled cycles.
    do_reset();
    bip_pc = 11'h7FF; bip_instruction = 16'h2001; bip_acc = 16'h1111;
    exp_frame = '{8'hA5, 8'h07, 8'hFF, 8'h00, 8'h00, 8'h11, 8'h11, 8'h00, 8'h15};
    send_cmd(8'h01);
    check("run_valid_on", 32'(bip_valid), 32'd1);
    repeat (20) @(negedge clock);
    check("run_still_on", 32'(bip_valid), 32'd1);
    bip_instruction = 16'h0000;
    @(negedge clock);
    check("run_hlt_drop", 32'(bip_valid), 32'd0);
    recv_frame("run", FLEN, -1, 8'h00);
    check("run_valid_cycles", 32'(valid_cycles), 32'd21);

    // RUN then BREAK after 8 cycles; STEP injected mid-frame is dropped.
    do_reset();
    bip_pc = 11'h456; bip_instruction = 16'h4321; bip_acc = 16'hCAFE;
    exp_frame = '{8'hA5, 8'h04, 8'h56, 8'h43, 8'h21, 8'hCA, 8'hFE, 8'h00, 8'h08};
    send_cmd(8'h01);
    repeat (6) @(negedge clock);
    send_cmd(8'h04);
    check("brk_drop", 32'(bip_valid), 32'd0);
    recv_frame("brk", FLEN, 2, 8'h02);
    check("brk_valid_cycles", 32'(valid_cycles), 32'd8);

    // Reset during frame byte 3, then a fresh DUMP.
    do_reset();
    bip_pc = 11'h321; bip_instruction = 16'h5A5A; bip_acc = 16'h0F0F;
    exp_frame = '{8'hA5, 8'h03, 8'h21, 8'h5A, 8'h5A, 8'h0F, 8'h0F, 8'h00, 8'h00};
    send_cmd(8'h03);
    recv_frame("pre_rst", 2, -1, 8'h00);
    wait_start("rst_b2");
    check("rst_b2_data", 32'(tx_data), 32'h21);
    #1 reset = 1'b1;
    #1 check("rst_abort", {22'd0, bip_valid, tx_start, tx_data, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_quiet", {30'd0, busy, tx_start}, 32'd0);
    bip_pc = 11'h0AB; bip_instruction = 16'h0800; bip_acc = 16'h1234;
    exp_frame = '{8'hA5, 8'h00, 8'hAB, 8'h08, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00};
    send_cmd(8'h03);
    recv_frame("post_rst", FLEN, -1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
